// File: rtl/mem_req_ctrl.sv
// Request front-end for the 64K x 9 parity memory: an in-order request FIFO feeding
// a four-state issue FSM, with read capture, odd-parity check and error counting.
module mem_req_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH:0]   mem_data_out,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_parity_err,
    output logic [7:0]            err_count,
    output logic                  busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2,
        WAIT_RD = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_reg, rd_ptr_reg;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop;
    logic [ENTRY_W-1:0]    head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic [ADDR_WIDTH-1:0] mem_address_reg;
    logic [DATA_WIDTH-1:0] mem_data_in_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  rsp_parity_err_reg;
    logic [7:0]            err_count_reg;
    logic                  parity_bad;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign push = req_valid && !fifo_full;
    assign pop  = !fifo_empty && (state_reg != OP_RD);

    assign head       = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_write = head[ENTRY_W-1];
    assign head_addr  = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign head_data  = head[DATA_WIDTH-1:0];

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            OP_RD:   state_next = WAIT_RD;
            default: begin
                if (!fifo_empty) begin
                    state_next = head_write ? OP_WR : OP_RD;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mem_write = (state_reg == OP_WR);
        mem_read  = (state_reg == OP_RD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_reg <= '0;
            mem_data_in_reg <= '0;
        end else if (pop) begin
            mem_address_reg <= head_addr;
            mem_data_in_reg <= head_data;
        end
    end

    // Good words have odd parity across all stored bits.
    assign parity_bad = ~^mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg      <= 1'b0;
            rsp_data_reg       <= '0;
            rsp_parity_err_reg <= 1'b0;
            err_count_reg      <= '0;
        end else begin
            rsp_valid_reg <= (state_reg == WAIT_RD);
            if (state_reg == WAIT_RD) begin
                rsp_data_reg       <= mem_data_out[DATA_WIDTH-1:0];
                rsp_parity_err_reg <= parity_bad;
                if (parity_bad && (err_count_reg != 8'hFF)) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
            end
        end
    end

    assign req_ready      = !fifo_full;
    assign mem_address    = mem_address_reg;
    assign mem_data_in    = mem_data_in_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_parity_err = rsp_parity_err_reg;
    assign err_count      = err_count_reg;
    assign busy           = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 64K x 9 parity memory;
// stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_mem_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [8:0]  mem_data_out;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_parity_err;
    logic [7:0]  err_count;
    logic        busy;

    mem_req_ctrl #(
        .FIFO_DEPTH(4),
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_parity_err(rsp_parity_err),
        .err_count     (err_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic saw_full = 1'b0;
    logic force_en = 1'b0;
    logic [8:0] force_val = 9'h000;
    logic [8:0] mem_model [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write stores the odd-parity word, read registers data_out.
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_address] <= {~^mem_data_in, mem_data_in};
        if (mem_read)  mem_data_out <= force_en ? force_val : mem_model[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !req_ready) saw_full <= 1'b1;
        if (rst_n && rsp_valid) begin
            $display("RSP cyc=%0d data=%02h perr=%0b cnt=%0d", cyc, rsp_data, rsp_parity_err, err_count);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                check("rsp_parity_err", {31'd0, rsp_parity_err}, {31'd0, e.perr});
                check("err_count", {24'd0, err_count}, {24'd0, e.cnt});
                if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_mem_rw"}, {30'd0, mem_write, mem_read}, 32'd0);
        check({tag, "_mem_address"}, {16'd0, mem_address}, 32'd0);
        check({tag, "_mem_data_in"}, {24'd0, mem_data_in}, 32'd0);
        check({tag, "_rsp"}, {22'd0, rsp_valid, rsp_parity_err, rsp_data}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Hold request until accepted; returns the cycle number of the accepting edge.
    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d, output int acc);
        int t;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        $display("REQ cyc=%0d write=%0b addr=%04h wdata=%02h", acc, w, a, d);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_rsp(input logic [7:0] d, input logic p, input logic [7:0] c, input int cy);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.cnt  = c;
        e.cyc  = cy;
        sb.push_back(e);
    endtask

    initial begin
        int acc;
        int first;
        logic [7:0] exp_cnt;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        #1;
        check_reset_outputs("init");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Write 0xA5 to 0x1234 then read it back: response 3 edges after read accept.
        send(1'b1, 16'h1234, 8'hA5, acc);
        send(1'b0, 16'h1234, 8'h00, acc);
        expect_rsp(8'hA5, 1'b0, 8'd0, acc + 3);
        drain();

        // Preload addresses used by the full-FIFO burst.
        send(1'b1, 16'h0100, 8'h11, acc);
        send(1'b1, 16'h0101, 8'h22, acc);
        for (int i = 0; i < 6; i++) send(1'b1, 16'(i), 8'h30 + 8'(i), acc);
        drain();
        check("mem_address_last_write", {16'd0, mem_address}, 32'h0005);

        // Eight back-to-back reads (two leaders + addresses 0..5) overrun the 4-deep FIFO.
        saw_full = 1'b0;
        send(1'b0, 16'h0100, 8'h00, first);
        expect_rsp(8'h11, 1'b0, 8'd0, first + 3);
        send(1'b0, 16'h0101, 8'h00, acc);
        expect_rsp(8'h22, 1'b0, 8'd0, first + 5);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 16'(i), 8'h00, acc);
            expect_rsp(8'h30 + 8'(i), 1'b0, 8'd0, first + 7 + 2 * i);
        end
        drain();
        check("req_ready_dropped", {31'd0, saw_full}, 32'd1);

        // Parity: 0x0A5 is an error, 0x1A5 is good.
        force_en  = 1'b1;
        force_val = 9'h0A5;
        send(1'b0, 16'h0020, 8'h00, acc);
        expect_rsp(8'hA5, 1'b1, 8'd1, acc + 3);
        drain();
        force_val = 9'h1A5;
        send(1'b0, 16'h0021, 8'h00, acc);
        expect_rsp(8'hA5, 1'b0, 8'd1, acc + 3);
        drain();

        // Saturation: 260 reads of an all-zero (bad parity) word.
        force_val = 9'h000;
        exp_cnt   = 8'd1;
        for (int i = 0; i < 260; i++) begin
            exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
            send(1'b0, 16'h0040 + 16'(i), 8'h00, acc);
            expect_rsp(8'h00, 1'b1, exp_cnt, -1);
        end
        drain();
        check("err_count_saturated", {24'd0, err_count}, 32'd255);
        force_en = 1'b0;

        // Reset while in WAIT_RD with two entries queued; no responses are expected.
        send(1'b0, 16'h0003, 8'h00, acc);
        send(1'b0, 16'h0004, 8'h00, acc);
        send(1'b0, 16'h0005, 8'h00, acc);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midread");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_idle", {29'd0, mem_write, mem_read, busy}, 32'd0);
            check("post_reset_ready", {31'd0, req_ready}, 32'd1);
        end

        // Recovery: a fresh read after reset works with a cleared counter.
        send(1'b0, 16'h0002, 8'h00, acc);
        expect_rsp(8'h32, 1'b0, 8'd0, acc + 3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
